omsp_spm_violation_ctrl: RTL and testbench
==========================================

Name: omsp_spm_violation_ctrl

Overview:
Downstream consumer of the per-SM violation outputs of every protected-module (SPM) instance. Merges CPU-side and DMA-side violations, captures fault context (pc, mab, SM index, cause), and raises a violation IRQ to the core. A second violation before software clears the first escalates to a timed reset request. Sits between the SPM array and the openMSP430 interrupt/clock-reset logic.

Parameters:
NUM_SPMS, 4, number of SPM instances feeding the vector inputs (1..16)
IDX_W, 2, width of captured SM index; must satisfy 2**IDX_W >= NUM_SPMS
RST_CYCLES, 8, cycles viol_rst_req is held asserted (>=1)
CNT_W, 8, width of saturating violation counter

Ports:
mclk  in  1  main clock
puc_rst_n  in  1  reset, asynchronous, active-low
spm_violation  in  NUM_SPMS  per-SM CPU violation (one bit per SPM instance)
spm_dma_violation  in  NUM_SPMS  per-SM DMA violation
pc  in  16  current program counter
mab  in  16  memory address bus
handling_irq  in  1  core currently in IRQ entry sequence
irq_ack  in  1  one-cycle acknowledge of viol_irq from interrupt controller
viol_clr  in  1  one-cycle software clear (handler finished)
viol_irq  out  1  violation interrupt request
viol_rst_req  out  1  reset request to clock/reset module
viol_pc  out  16  captured pc (0 if captured during handling_irq)
viol_addr  out  16  captured mab
viol_sm_idx  out  IDX_W  lowest-index violating SM
viol_cause  out  2  bit0 CPU violation, bit1 DMA violation
viol_count  out  CNT_W  saturating count of accepted violation events
busy  out  1  state != IDLE

Behaviour:
- One clock (mclk); reset asynchronous, active-low (puc_rst_n). All state updates on posedge mclk.
- Reset: state IDLE; viol_irq=0, viol_rst_req=0, viol_pc=0, viol_addr=0, viol_sm_idx=0, viol_cause=0, viol_count=0, busy=0, reset-hold counter=0.
- Event: any_viol = |(spm_violation | spm_dma_violation). An event is sampled per cycle; a violation held high N cycles counts as N events for escalation but only per-cycle once for the counter.
- States: IDLE, IRQ_PEND, HANDLING, RESET.
- IDLE: on any_viol -> capture context, viol_count+1, go IRQ_PEND; viol_irq high the following cycle (latency 1).
- Capture: viol_sm_idx = lowest i with spm_violation[i]|spm_dma_violation[i]; viol_cause = {|spm_dma_violation, |spm_violation}; viol_addr = mab; viol_pc = handling_irq ? 0 : pc. Capture registers only update on IDLE->IRQ_PEND; held until next capture.
- IRQ_PEND: viol_irq=1. irq_ack -> HANDLING (viol_irq low next cycle). any_viol (including same cycle as irq_ack) -> RESET (escalation wins).
- HANDLING: viol_irq=0. viol_clr -> IDLE. any_viol -> RESET; any_viol and viol_clr same cycle -> RESET.
- RESET: viol_rst_req=1 for exactly RST_CYCLES cycles (counter loaded with RST_CYCLES-1 on entry, decrements), then IDLE; viol_irq=0; inputs ignored, counter not incremented. Capture registers keep first-fault context.
- viol_count increments by 1 on every accepted event (IDLE entry and escalation entry), saturates at all-ones, never wraps; cleared only by puc_rst_n.
- irq_ack/viol_clr outside their consuming state: ignored.
- Reset mid-operation (any state): immediate return to reset values, viol_rst_req and viol_irq drop asynchronously.
- busy = (state != IDLE), registered-state decode.

Test Plan:
- Reset then spm_violation=4'b0100 one cycle, pc=16'h8010, mab=16'h0200 -> next cycle viol_irq=1, viol_sm_idx=2, viol_cause=2'b01, viol_pc=8010, viol_addr=0200, viol_count=1.
- spm_violation=4'b0000, spm_dma_violation=4'b1010, handling_irq=1 -> viol_sm_idx=1, viol_cause=2'b10, viol_pc=0000.
- Violation, irq_ack, viol_clr -> states IRQ_PEND, HANDLING, IDLE; viol_irq high exactly until cycle after ack; busy=0 after clear; no viol_rst_req.
- Violation, irq_ack, second violation in HANDLING same cycle as viol_clr -> viol_rst_req high exactly 8 cycles, then IDLE; viol_count=2; capture fields still hold first fault.
- 300 isolated violation/ack/clr sequences with CNT_W=8 -> viol_count saturates at 255, no wrap.
- Assert puc_rst_n low mid-RESET (cycle 3 of 8) -> viol_rst_req drops without waiting for clock edge; all outputs return to reset values.

Source files
------------

// File: rtl/omsp_spm_violation_ctrl.sv
// SPM violation controller: merges CPU/DMA violations from all SPM instances, captures the
// first-fault context, raises a violation IRQ and escalates a repeated violation to a timed
// reset request.
module omsp_spm_violation_ctrl #(
    parameter int unsigned NUM_SPMS   = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned RST_CYCLES = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                mclk,
    input  logic                puc_rst_n,
    input  logic [NUM_SPMS-1:0] spm_violation,
    input  logic [NUM_SPMS-1:0] spm_dma_violation,
    input  logic [15:0]         pc,
    input  logic [15:0]         mab,
    input  logic                handling_irq,
    input  logic                irq_ack,
    input  logic                viol_clr,
    output logic                viol_irq,
    output logic                viol_rst_req,
    output logic [15:0]         viol_pc,
    output logic [15:0]         viol_addr,
    output logic [IDX_W-1:0]    viol_sm_idx,
    output logic [1:0]          viol_cause,
    output logic [CNT_W-1:0]    viol_count,
    output logic                busy
);

    // Reset-hold counter must be at least one bit even when RST_CYCLES == 1.
    localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StIrqPend, StHandling, StReset} state_e;

    state_e            state_q, state_d;
    logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [15:0]       pc_q, pc_d;
    logic [15:0]       addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [NUM_SPMS-1:0] viol_vec;
    logic                any_viol;
    logic [IDX_W-1:0]    low_idx;
    logic                capture_en;
    logic                accept;

    assign viol_vec = spm_violation | spm_dma_violation;
    assign any_viol = |viol_vec;

    // Priority encoder: scan high to low so the lowest set index wins.
    always_comb begin
        low_idx = '0;
        for (int i = int'(NUM_SPMS) - 1; i >= 0; i--) begin
            if (viol_vec[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q   <= StIdle;
            rst_cnt_q <= '0;
            pc_q      <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            cause_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            cause_q   <= cause_d;
            count_q   <= count_d;
        end
    end

    // Next-state logic; a violation in IRQ_PEND/HANDLING beats ack/clear in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_viol) state_d = StIrqPend;
            end
            StIrqPend: begin
                if (any_viol)     state_d = StReset;
                else if (irq_ack) state_d = StHandling;
            end
            StHandling: begin
                if (any_viol)      state_d = StReset;
                else if (viol_clr) state_d = StIdle;
            end
            StReset: begin
                if (rst_cnt_q == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Capture, event counter and reset-hold counter next-state.
    always_comb begin
        capture_en = (state_q == StIdle) && any_viol;
        accept     = capture_en ||
                     (((state_q == StIrqPend) || (state_q == StHandling)) && any_viol);

        pc_d    = pc_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        cause_d = cause_q;
        if (capture_en) begin
            pc_d    = handling_irq ? 16'h0000 : pc;
            addr_d  = mab;
            idx_d   = low_idx;
            cause_d = {|spm_dma_violation, |spm_violation};
        end

        count_d = count_q;
        if (accept && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end

        rst_cnt_d = rst_cnt_q;
        if ((state_q != StReset) && (state_d == StReset)) begin
            rst_cnt_d = RstW'(RST_CYCLES - 1);
        end else if ((state_q == StReset) && (rst_cnt_q != '0)) begin
            rst_cnt_d = rst_cnt_q - 1'b1;
        end
    end

    // Outputs decoded from registered state so they drop with the asynchronous reset.
    always_comb begin
        viol_irq     = (state_q == StIrqPend);
        viol_rst_req = (state_q == StReset);
        busy         = (state_q != StIdle);
        viol_pc      = pc_q;
        viol_addr    = addr_q;
        viol_sm_idx  = idx_q;
        viol_cause   = cause_q;
        viol_count   = count_q;
    end

endmodule

// File: tb/tb_omsp_spm_violation_ctrl.sv
// Bench for omsp_spm_violation_ctrl: table of single-cycle vectors plus hand-written sequences
// for counter saturation and asynchronous reset during the reset-request window.
module tb_omsp_spm_violation_ctrl;

    logic        mclk = 1'b0;
    logic        puc_rst_n;
    logic [3:0]  spm_violation;
    logic [3:0]  spm_dma_violation;
    logic [15:0] pc;
    logic [15:0] mab;
    logic        handling_irq;
    logic        irq_ack;
    logic        viol_clr;
    logic        viol_irq;
    logic        viol_rst_req;
    logic [15:0] viol_pc;
    logic [15:0] viol_addr;
    logic [1:0]  viol_sm_idx;
    logic [1:0]  viol_cause;
    logic [7:0]  viol_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 mclk = ~mclk;

    omsp_spm_violation_ctrl #(
        .NUM_SPMS  (4),
        .IDX_W     (2),
        .RST_CYCLES(8),
        .CNT_W     (8)
    ) dut (
        .mclk             (mclk),
        .puc_rst_n        (puc_rst_n),
        .spm_violation    (spm_violation),
        .spm_dma_violation(spm_dma_violation),
        .pc               (pc),
        .mab              (mab),
        .handling_irq     (handling_irq),
        .irq_ack          (irq_ack),
        .viol_clr         (viol_clr),
        .viol_irq         (viol_irq),
        .viol_rst_req     (viol_rst_req),
        .viol_pc          (viol_pc),
        .viol_addr        (viol_addr),
        .viol_sm_idx      (viol_sm_idx),
        .viol_cause       (viol_cause),
        .viol_count       (viol_count),
        .busy             (busy)
    );

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  d;
        logic [15:0] pc;
        logic [15:0] mab;
        logic        hi;
        logic        ack;
        logic        clr;
        logic        e_irq;
        logic        e_rst;
        logic [15:0] e_pc;
        logic [15:0] e_addr;
        logic [1:0]  e_idx;
        logic [1:0]  e_cause;
        logic [7:0]  e_cnt;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic irq, input logic rst,
                           input logic [15:0] epc, input logic [15:0] eaddr,
                           input logic [1:0] idx, input logic [1:0] cause,
                           input logic [7:0] cnt, input logic bsy);
        chk({tag, ".viol_irq"},     32'(viol_irq),     32'(irq));
        chk({tag, ".viol_rst_req"}, 32'(viol_rst_req), 32'(rst));
        chk({tag, ".viol_pc"},      32'(viol_pc),      32'(epc));
        chk({tag, ".viol_addr"},    32'(viol_addr),    32'(eaddr));
        chk({tag, ".viol_sm_idx"},  32'(viol_sm_idx),  32'(idx));
        chk({tag, ".viol_cause"},   32'(viol_cause),   32'(cause));
        chk({tag, ".viol_count"},   32'(viol_count),   32'(cnt));
        chk({tag, ".busy"},         32'(busy),         32'(bsy));
    endtask

    task automatic idle_inputs();
        spm_violation     = '0;
        spm_dma_violation = '0;
        pc                = '0;
        mab               = '0;
        handling_irq      = 1'b0;
        irq_ack           = 1'b0;
        viol_clr          = 1'b0;
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic cycle(input logic [3:0] v, input logic [3:0] d, input logic ack,
                         input logic clr);
        @(negedge mclk);
        spm_violation     = v;
        spm_dma_violation = d;
        irq_ack           = ack;
        viol_clr          = clr;
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge mclk);
        idle_inputs();
        puc_rst_n = 1'b0;
        @(negedge mclk);
        puc_rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] d, input logic [15:0] p,
                                input logic [15:0] m, input logic hi, input logic ack,
                                input logic clr, input logic irq, input logic rst,
                                input logic [15:0] epc, input logic [15:0] eaddr,
                                input logic [1:0] idx, input logic [1:0] cause,
                                input logic [7:0] cnt, input logic bsy);
        vec_t r;
        r.v = v; r.d = d; r.pc = p; r.mab = m; r.hi = hi; r.ack = ack; r.clr = clr;
        r.e_irq = irq; r.e_rst = rst; r.e_pc = epc; r.e_addr = eaddr; r.e_idx = idx;
        r.e_cause = cause; r.e_cnt = cnt; r.e_busy = bsy;
        return r;
    endfunction

    initial begin
        int exp_cnt;
        // v, d, pc, mab, hi, ack, clr | irq, rst, pc, addr, idx, cause, cnt, busy
        // CPU violation on SM2 -> IRQ_PEND
        vecs.push_back(mk(4'b0100, 4'h0, 16'h8010, 16'h0200, 0, 0, 0,
                          1, 0, 16'h8010, 16'h0200, 2'd2, 2'b01, 8'd1, 1));
        // ack -> HANDLING
        vecs.push_back(mk(4'h0, 4'h0, 16'h1111, 16'h2222, 0, 1, 0,
                          0, 0, 16'h8010, 16'h0200, 2'd2, 2'b01, 8'd1, 1));
        // clear -> IDLE
        vecs.push_back(mk(4'h0, 4'h0, 16'h1111, 16'h2222, 0, 0, 1,
                          0, 0, 16'h8010, 16'h0200, 2'd2, 2'b01, 8'd1, 0));
        // DMA violation during IRQ entry: pc captured as 0, lowest SM is 1
        vecs.push_back(mk(4'h0, 4'b1010, 16'h1234, 16'h0300, 1, 0, 0,
                          1, 0, 16'h0000, 16'h0300, 2'd1, 2'b10, 8'd2, 1));
        vecs.push_back(mk(4'h0, 4'h0, 16'h9999, 16'h9999, 0, 1, 0,
                          0, 0, 16'h0000, 16'h0300, 2'd1, 2'b10, 8'd2, 1));
        // violation with clear in HANDLING -> RESET, first-fault context kept
        vecs.push_back(mk(4'b0001, 4'h0, 16'hAAAA, 16'hBBBB, 0, 0, 1,
                          0, 1, 16'h0000, 16'h0300, 2'd1, 2'b10, 8'd3, 1));
        // seven more reset cycles; inputs in RESET are ignored
        for (int i = 0; i < 7; i++) begin
            vecs.push_back(mk((i == 1) ? 4'hF : 4'h0, (i == 2) ? 4'hF : 4'h0, 16'hCCCC,
                              16'hDDDD, 0, 1, 1,
                              0, 1, 16'h0000, 16'h0300, 2'd1, 2'b10, 8'd3, 1));
        end
        // reset window over -> IDLE
        vecs.push_back(mk(4'h0, 4'h0, 16'h0, 16'h0, 0, 0, 0,
                          0, 0, 16'h0000, 16'h0300, 2'd1, 2'b10, 8'd3, 0));
        // ack/clr in IDLE ignored
        vecs.push_back(mk(4'h0, 4'h0, 16'h0, 16'h0, 0, 1, 1,
                          0, 0, 16'h0000, 16'h0300, 2'd1, 2'b10, 8'd3, 0));
        // mixed CPU SM3 + DMA SM0 -> idx 0, cause 11
        vecs.push_back(mk(4'b1000, 4'b0001, 16'h4444, 16'h5555, 0, 0, 0,
                          1, 0, 16'h4444, 16'h5555, 2'd0, 2'b11, 8'd4, 1));
        // violation same cycle as ack -> escalation wins
        vecs.push_back(mk(4'b0010, 4'h0, 16'h6666, 16'h7777, 0, 1, 0,
                          0, 1, 16'h4444, 16'h5555, 2'd0, 2'b11, 8'd5, 1));

        idle_inputs();
        puc_rst_n = 1'b0;
        #12;
        chk_all("reset", 0, 0, 16'h0, 16'h0, 2'd0, 2'b00, 8'd0, 0);
        @(negedge mclk);
        puc_rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge mclk);
            spm_violation     = vecs[k].v;
            spm_dma_violation = vecs[k].d;
            pc                = vecs[k].pc;
            mab               = vecs[k].mab;
            handling_irq      = vecs[k].hi;
            irq_ack           = vecs[k].ack;
            viol_clr          = vecs[k].clr;
            @(posedge mclk);
            #1;
            chk_all($sformatf("vec%0d", k), vecs[k].e_irq, vecs[k].e_rst, vecs[k].e_pc,
                    vecs[k].e_addr, vecs[k].e_idx, vecs[k].e_cause, vecs[k].e_cnt,
                    vecs[k].e_busy);
        end

        // Saturation: 300 isolated violation/ack/clear sequences.
        do_reset();
        exp_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            cycle(4'b0001, 4'h0, 1'b0, 1'b0);
            cycle(4'h0, 4'h0, 1'b1, 1'b0);
            cycle(4'h0, 4'h0, 1'b0, 1'b1);
            if (exp_cnt < 255) exp_cnt++;
            if (n >= 250 || (n % 50) == 0) begin
                chk($sformatf("sat%0d.viol_count", n), 32'(viol_count), 32'(exp_cnt));
            end
        end
        chk("sat.no_rst_req", 32'(viol_rst_req), 32'd0);
        chk("sat.busy", 32'(busy), 32'd0);

        // Asynchronous reset during the third reset-request cycle.
        do_reset();
        pc  = 16'h0ABC;
        mab = 16'h0DEF;
        cycle(4'b0100, 4'h0, 1'b0, 1'b0);
        cycle(4'b0100, 4'h0, 1'b0, 1'b0);
        chk("escal.viol_rst_req", 32'(viol_rst_req), 32'd1);
        cycle(4'h0, 4'h0, 1'b0, 1'b0);
        cycle(4'h0, 4'h0, 1'b0, 1'b0);
        chk("escal.cycle3", 32'(viol_rst_req), 32'd1);
        #2;
        puc_rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 16'h0, 16'h0, 2'd0, 2'b00, 8'd0, 0);
        @(negedge mclk);
        idle_inputs();
        puc_rst_n = 1'b1;
        cycle(4'h0, 4'h0, 1'b0, 1'b0);
        chk_all("post_rst", 0, 0, 16'h0, 16'h0, 2'd0, 2'b00, 8'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
